io_port_buffered: RTL and testbench
===================================

Name: io_port_buffered

Overview:
Parametrised buffered I/O port that replaces the processor's single-register in_port/out_port path. An input FIFO collects words from an external producer over a valid/ready handshake, and the CPU drains it with a read strobe. An output FIFO accepts CPU writes and presents them to an external consumer over valid/ready. The block sits between the processor datapath I/O instructions and the top-level pins, and adds sticky underflow/overflow status that the plain port never had.

Parameters:
BUS_WIDTH, 16, data width of all data ports
FIFO_DEPTH, 4, entries per FIFO; power of two, >= 2
CNT_W, $clog2(FIFO_DEPTH)+1, width of occupancy counters (derived, not overridden)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-low reset
ext_in_data  input  BUS_WIDTH  producer data
ext_in_valid  input  1  producer data valid
ext_in_ready  output  1  input FIFO can accept
cpu_rd_en  input  1  CPU read strobe (IN instruction)
cpu_rd_data  output  BUS_WIDTH  registered read data
cpu_wr_en  input  1  CPU write strobe (OUT instruction)
cpu_wr_data  input  BUS_WIDTH  CPU write data
ext_out_data  output  BUS_WIDTH  head of output FIFO
ext_out_valid  output  1  output FIFO non-empty
ext_out_ready  input  1  consumer accepts
in_count  output  CNT_W  input FIFO occupancy
out_count  output  CNT_W  output FIFO occupancy
status_clr  input  1  clears sticky flags
underflow  output  1  sticky: CPU read while input FIFO empty
overflow  output  1  sticky: CPU write while output FIFO full

Behaviour:
- Reset (rst=0, async): all pointers and counts 0; cpu_rd_data=0; underflow=overflow=0; ext_in_ready=1; ext_out_valid=0; ext_out_data undefined-safe (0). FIFO storage is not cleared. Reset mid-transfer discards all buffered words.
- Storage: two circular buffers. Write/read pointers are log2(FIFO_DEPTH) bits wide and wrap modulo FIFO_DEPTH. Counts track occupancy 0..FIFO_DEPTH.
- Input side:
  - ext_in_ready = (in_count != FIFO_DEPTH), driven from registered state only.
  - Push on rising edge when ext_in_valid && ext_in_ready.
- CPU read:
  - If cpu_rd_en && in_count != 0: cpu_rd_data <= head and pop. Data is visible one cycle after the strobe.
  - If cpu_rd_en && in_count == 0: cpu_rd_data holds its value, underflow <= 1, no pop.
  - No bypass: a push and a read on an empty FIFO in the same cycle give underflow, and the pushed word stays queued.
- Input FIFO simultaneous push+pop when 0 < in_count < FIFO_DEPTH: count unchanged, both pointers advance. When full, ready is already low, so only the pop occurs.
- CPU write:
  - If cpu_wr_en && out_count != FIFO_DEPTH: write cpu_wr_data at the tail.
  - If cpu_wr_en while full: the word is dropped and overflow <= 1. This holds even if the consumer pops in the same cycle, because the decision uses the registered count.
- Output side:
  - ext_out_valid = (out_count != 0).
  - ext_out_data = storage[out read pointer], combinational from registered state.
  - Pop when ext_out_valid && ext_out_ready.
  - Simultaneous write and pop on a non-full, non-empty FIFO leaves count unchanged.
  - Write to an empty FIFO: valid rises the following cycle. No same-cycle pass-through.
- Sticky flags: status_clr clears both flags. If a set event and status_clr occur in the same cycle, set wins (flag = 1).
- ext_out_data is held stable while ext_out_valid=1 and ext_out_ready=0.
- No combinational path from any input to any output except storage-read muxing on ext_out_data.

Test Plan:
- Reset then idle -> ext_in_ready=1, ext_out_valid=0, counts=0, cpu_rd_data=0, flags=0.
- Push 0x0011,0x0022,0x0033,0x0044 (DEPTH=4) with valid held high, then a 5th word 0x0055 -> ext_in_ready=0 after the 4th push, 0x0055 not accepted. Four cpu_rd_en pulses return 0x0011..0x0044, each one cycle after its strobe. A 5th read sets underflow=1 and cpu_rd_data stays 0x0044.
- CPU writes 0xA000..0xA004 with ext_out_ready=0 -> out_count=4, 5th write dropped, overflow=1. Raise ready -> ext_out_data sequence 0xA000..0xA003, then valid=0.
- Full output FIFO, cpu_wr_en and ext_out_ready in the same cycle -> pop occurs, write dropped, overflow=1, out_count=3.
- underflow event with status_clr asserted in the same cycle -> underflow=1. status_clr alone next cycle -> underflow=0.
- Push 3 words, pull rst low mid-cycle (asynchronous) -> in_count=0 immediately, ext_in_ready=1. A subsequent read sets underflow.

Source files
------------

// File: rtl/io_port_buffered.sv
// Buffered CPU I/O port: input FIFO (producer -> CPU read strobe) and output FIFO
// (CPU write strobe -> consumer), with sticky underflow/overflow status.
module io_port_buffered #(
   parameter int unsigned BUS_WIDTH  = 16,
   parameter int unsigned FIFO_DEPTH = 4,
   localparam int unsigned CNT_W     = $clog2(FIFO_DEPTH) + 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [BUS_WIDTH-1:0] ext_in_data,
   input  logic                 ext_in_valid,
   output logic                 ext_in_ready,
   input  logic                 cpu_rd_en,
   output logic [BUS_WIDTH-1:0] cpu_rd_data,
   input  logic                 cpu_wr_en,
   input  logic [BUS_WIDTH-1:0] cpu_wr_data,
   output logic [BUS_WIDTH-1:0] ext_out_data,
   output logic                 ext_out_valid,
   input  logic                 ext_out_ready,
   output logic [CNT_W-1:0]     in_count,
   output logic [CNT_W-1:0]     out_count,
   input  logic                 status_clr,
   output logic                 underflow,
   output logic                 overflow
);

   localparam int unsigned      PTR_W   = $clog2(FIFO_DEPTH);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

   logic [BUS_WIDTH-1:0] in_mem_q  [FIFO_DEPTH];
   logic [BUS_WIDTH-1:0] out_mem_q [FIFO_DEPTH];

   logic [PTR_W-1:0]     in_wptr_q, in_wptr_d, in_rptr_q, in_rptr_d;
   logic [PTR_W-1:0]     out_wptr_q, out_wptr_d, out_rptr_q, out_rptr_d;
   logic [CNT_W-1:0]     in_cnt_q, in_cnt_d, out_cnt_q, out_cnt_d;
   logic [BUS_WIDTH-1:0] rd_data_q, rd_data_d;
   logic                 underflow_q, underflow_d, overflow_q, overflow_d;
   logic                 in_push, in_pop, out_push, out_pop;

   // All push/pop decisions use registered counts only: no bypass, no pass-through.
   always_comb begin
      in_push    = ext_in_valid && (in_cnt_q != CNT_FULL);
      in_pop     = cpu_rd_en && (in_cnt_q != '0);
      out_push   = cpu_wr_en && (out_cnt_q != CNT_FULL);
      out_pop    = ext_out_ready && (out_cnt_q != '0);

      in_wptr_d  = in_push  ? in_wptr_q + PTR_ONE  : in_wptr_q;
      in_rptr_d  = in_pop   ? in_rptr_q + PTR_ONE  : in_rptr_q;
      out_wptr_d = out_push ? out_wptr_q + PTR_ONE : out_wptr_q;
      out_rptr_d = out_pop  ? out_rptr_q + PTR_ONE : out_rptr_q;

      in_cnt_d = in_cnt_q;
      case ({in_push, in_pop})
         2'b10:   in_cnt_d = in_cnt_q + CNT_ONE;
         2'b01:   in_cnt_d = in_cnt_q - CNT_ONE;
         default: in_cnt_d = in_cnt_q;
      endcase

      out_cnt_d = out_cnt_q;
      case ({out_push, out_pop})
         2'b10:   out_cnt_d = out_cnt_q + CNT_ONE;
         2'b01:   out_cnt_d = out_cnt_q - CNT_ONE;
         default: out_cnt_d = out_cnt_q;
      endcase

      rd_data_d = in_pop ? in_mem_q[in_rptr_q] : rd_data_q;

      // Set beats clear when both land in the same cycle.
      underflow_d = status_clr ? 1'b0 : underflow_q;
      overflow_d  = status_clr ? 1'b0 : overflow_q;
      if (cpu_rd_en && (in_cnt_q == '0))     underflow_d = 1'b1;
      if (cpu_wr_en && (out_cnt_q == CNT_FULL)) overflow_d = 1'b1;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         in_wptr_q   <= '0;
         in_rptr_q   <= '0;
         out_wptr_q  <= '0;
         out_rptr_q  <= '0;
         in_cnt_q    <= '0;
         out_cnt_q   <= '0;
         rd_data_q   <= '0;
         underflow_q <= 1'b0;
         overflow_q  <= 1'b0;
      end else begin
         in_wptr_q   <= in_wptr_d;
         in_rptr_q   <= in_rptr_d;
         out_wptr_q  <= out_wptr_d;
         out_rptr_q  <= out_rptr_d;
         in_cnt_q    <= in_cnt_d;
         out_cnt_q   <= out_cnt_d;
         rd_data_q   <= rd_data_d;
         underflow_q <= underflow_d;
         overflow_q  <= overflow_d;
      end
   end

   // Storage is deliberately not reset.
   always_ff @(posedge clk) begin
      if (in_push)  in_mem_q[in_wptr_q]   <= ext_in_data;
      if (out_push) out_mem_q[out_wptr_q] <= cpu_wr_data;
   end

   assign ext_in_ready  = (in_cnt_q != CNT_FULL);
   assign ext_out_valid = (out_cnt_q != '0);
   // Gate to zero when empty so uninitialised storage never reaches the pins.
   assign ext_out_data  = ext_out_valid ? out_mem_q[out_rptr_q] : '0;
   assign cpu_rd_data   = rd_data_q;
   assign in_count      = in_cnt_q;
   assign out_count     = out_cnt_q;
   assign underflow     = underflow_q;
   assign overflow      = overflow_q;

endmodule

// File: tb/tb_io_port_buffered.sv
// Bench for io_port_buffered: directed vector table, async-reset sequence, and
// randomized traffic against a queue-based reference model.
module tb_io_port_buffered;

   localparam int D = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [15:0] ext_in_data = '0;
   logic        ext_in_valid = 1'b0;
   logic        ext_in_ready;
   logic        cpu_rd_en = 1'b0;
   logic [15:0] cpu_rd_data;
   logic        cpu_wr_en = 1'b0;
   logic [15:0] cpu_wr_data = '0;
   logic [15:0] ext_out_data;
   logic        ext_out_valid;
   logic        ext_out_ready = 1'b0;
   logic [2:0]  in_count, out_count;
   logic        status_clr = 1'b0;
   logic        underflow, overflow;

   io_port_buffered #(.BUS_WIDTH(16), .FIFO_DEPTH(D)) dut (
      .clk(clk), .rst(rst),
      .ext_in_data(ext_in_data), .ext_in_valid(ext_in_valid), .ext_in_ready(ext_in_ready),
      .cpu_rd_en(cpu_rd_en), .cpu_rd_data(cpu_rd_data),
      .cpu_wr_en(cpu_wr_en), .cpu_wr_data(cpu_wr_data),
      .ext_out_data(ext_out_data), .ext_out_valid(ext_out_valid), .ext_out_ready(ext_out_ready),
      .in_count(in_count), .out_count(out_count),
      .status_clr(status_clr), .underflow(underflow), .overflow(overflow)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_bad = 0;

   typedef struct {
      logic iv; logic [15:0] id; logic rd; logic wr; logic [15:0] wd; logic ordy; logic clr;
      logic [2:0] e_inc; logic [2:0] e_outc; logic [15:0] e_rd; logic e_uf; logic e_of;
      logic [15:0] e_od;
   } vec_t;

   function automatic vec_t mkv(logic iv, logic [15:0] id, logic rd, logic wr, logic [15:0] wd,
                                logic ordy, logic clr, logic [2:0] inc, logic [2:0] outc,
                                logic [15:0] rdd, logic uf, logic of, logic [15:0] od);
      vec_t v;
      v.iv = iv; v.id = id; v.rd = rd; v.wr = wr; v.wd = wd; v.ordy = ordy; v.clr = clr;
      v.e_inc = inc; v.e_outc = outc; v.e_rd = rdd; v.e_uf = uf; v.e_of = of; v.e_od = od;
      return v;
   endfunction

   // Reference model: plain queues and sticky bits.
   logic [15:0] m_in[$];
   logic [15:0] m_out[$];
   logic [15:0] m_rd = '0;
   logic        m_uf = 1'b0, m_of = 1'b0;

   task automatic model_reset();
      m_in.delete(); m_out.delete(); m_rd = '0; m_uf = 1'b0; m_of = 1'b0;
   endtask

   task automatic model_clock();
      int  isz = m_in.size();
      int  osz = m_out.size();
      logic uf_ev = cpu_rd_en && (isz == 0);
      logic of_ev = cpu_wr_en && (osz == D);
      if (cpu_rd_en && isz != 0) m_rd = m_in.pop_front();
      if (ext_in_valid && isz != D) m_in.push_back(ext_in_data);
      if (ext_out_ready && osz != 0) void'(m_out.pop_front());
      if (cpu_wr_en && osz != D) m_out.push_back(cpu_wr_data);
      if (status_clr) begin m_uf = 1'b0; m_of = 1'b0; end
      if (uf_ev) m_uf = 1'b1;
      if (of_ev) m_of = 1'b1;
   endtask

   function automatic logic [63:0] pack(logic irdy, logic ov, logic [2:0] inc, logic [2:0] outc,
                                        logic [15:0] rdd, logic [15:0] od, logic uf, logic of);
      return {22'd0, irdy, ov, inc, outc, rdd, od, uf, of};
   endfunction

   function automatic logic [63:0] dut_bundle();
      return pack(ext_in_ready, ext_out_valid, in_count, out_count, cpu_rd_data, ext_out_data,
                  underflow, overflow);
   endfunction

   function automatic logic [63:0] model_bundle();
      return pack(m_in.size() != D, m_out.size() != 0, 3'(m_in.size()), 3'(m_out.size()), m_rd,
                  (m_out.size() != 0) ? m_out[0] : 16'h0, m_uf, m_of);
   endfunction

   task automatic check(string name, logic [63:0] act, logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got irdy=%b ov=%b inc=%0d outc=%0d rd=%h od=%h uf=%b of=%b, want irdy=%b ov=%b inc=%0d outc=%0d rd=%h od=%h uf=%b of=%b",
                  name, act[41], act[40], act[39:37], act[36:34], act[33:18], act[17:2], act[1],
                  act[0], exp[41], exp[40], exp[39:37], exp[36:34], exp[33:18], exp[17:2],
                  exp[1], exp[0]);
      end
   endtask

   // Drive on the falling edge, clock the model with the DUT, sample 1 time unit later.
   task automatic step(logic iv, logic [15:0] id, logic rd, logic wr, logic [15:0] wd,
                       logic ordy, logic clr);
      @(negedge clk);
      ext_in_valid = iv; ext_in_data = id; cpu_rd_en = rd; cpu_wr_en = wr; cpu_wr_data = wd;
      ext_out_ready = ordy; status_clr = clr;
      @(posedge clk);
      model_clock();
      #1;
   endtask

   vec_t tbl[$];

   initial begin
      tbl.push_back(mkv(1, 'h0011, 0, 0, 0, 0, 0, 1, 0, 'h0000, 0, 0, 'h0000));
      tbl.push_back(mkv(1, 'h0022, 0, 0, 0, 0, 0, 2, 0, 'h0000, 0, 0, 'h0000));
      tbl.push_back(mkv(1, 'h0033, 0, 0, 0, 0, 0, 3, 0, 'h0000, 0, 0, 'h0000));
      tbl.push_back(mkv(1, 'h0044, 0, 0, 0, 0, 0, 4, 0, 'h0000, 0, 0, 'h0000));
      tbl.push_back(mkv(1, 'h0055, 0, 0, 0, 0, 0, 4, 0, 'h0000, 0, 0, 'h0000));
      tbl.push_back(mkv(0, 'h0000, 1, 0, 0, 0, 0, 3, 0, 'h0011, 0, 0, 'h0000));
      tbl.push_back(mkv(0, 'h0000, 1, 0, 0, 0, 0, 2, 0, 'h0022, 0, 0, 'h0000));
      tbl.push_back(mkv(0, 'h0000, 1, 0, 0, 0, 0, 1, 0, 'h0033, 0, 0, 'h0000));
      tbl.push_back(mkv(0, 'h0000, 1, 0, 0, 0, 0, 0, 0, 'h0044, 0, 0, 'h0000));
      tbl.push_back(mkv(0, 'h0000, 1, 0, 0, 0, 0, 0, 0, 'h0044, 1, 0, 'h0000));
      tbl.push_back(mkv(0, 'h0000, 0, 0, 0, 0, 1, 0, 0, 'h0044, 0, 0, 'h0000));
      tbl.push_back(mkv(0, 'h0000, 0, 1, 'hA000, 0, 0, 0, 1, 'h0044, 0, 0, 'hA000));
      tbl.push_back(mkv(0, 'h0000, 0, 1, 'hA001, 0, 0, 0, 2, 'h0044, 0, 0, 'hA000));
      tbl.push_back(mkv(0, 'h0000, 0, 1, 'hA002, 0, 0, 0, 3, 'h0044, 0, 0, 'hA000));
      tbl.push_back(mkv(0, 'h0000, 0, 1, 'hA003, 0, 0, 0, 4, 'h0044, 0, 0, 'hA000));
      tbl.push_back(mkv(0, 'h0000, 0, 1, 'hA004, 0, 0, 0, 4, 'h0044, 0, 1, 'hA000));
      tbl.push_back(mkv(0, 'h0000, 0, 0, 0, 1, 1, 0, 3, 'h0044, 0, 0, 'hA001));
      tbl.push_back(mkv(0, 'h0000, 0, 0, 0, 1, 0, 0, 2, 'h0044, 0, 0, 'hA002));
      tbl.push_back(mkv(0, 'h0000, 0, 0, 0, 1, 0, 0, 1, 'h0044, 0, 0, 'hA003));
      tbl.push_back(mkv(0, 'h0000, 0, 0, 0, 1, 0, 0, 0, 'h0044, 0, 0, 'h0000));
      tbl.push_back(mkv(0, 'h0000, 0, 1, 'hB000, 0, 0, 0, 1, 'h0044, 0, 0, 'hB000));
      tbl.push_back(mkv(0, 'h0000, 0, 1, 'hB001, 0, 0, 0, 2, 'h0044, 0, 0, 'hB000));
      tbl.push_back(mkv(0, 'h0000, 0, 1, 'hB002, 0, 0, 0, 3, 'h0044, 0, 0, 'hB000));
      tbl.push_back(mkv(0, 'h0000, 0, 1, 'hB003, 0, 0, 0, 4, 'h0044, 0, 0, 'hB000));
      tbl.push_back(mkv(0, 'h0000, 0, 1, 'hB004, 1, 0, 0, 3, 'h0044, 0, 1, 'hB001));
      tbl.push_back(mkv(0, 'h0000, 0, 0, 0, 0, 1, 0, 3, 'h0044, 0, 0, 'hB001));
      tbl.push_back(mkv(0, 'h0000, 1, 0, 0, 0, 1, 0, 3, 'h0044, 1, 0, 'hB001));
      tbl.push_back(mkv(0, 'h0000, 0, 0, 0, 0, 1, 0, 3, 'h0044, 0, 0, 'hB001));
      tbl.push_back(mkv(1, 'h0077, 0, 0, 0, 0, 0, 1, 3, 'h0044, 0, 0, 'hB001));
      tbl.push_back(mkv(1, 'h0088, 1, 0, 0, 0, 0, 1, 3, 'h0077, 0, 0, 'hB001));
      tbl.push_back(mkv(0, 'h0000, 1, 0, 0, 0, 0, 0, 3, 'h0088, 0, 0, 'hB001));
      tbl.push_back(mkv(1, 'h0099, 1, 0, 0, 0, 0, 1, 3, 'h0088, 1, 0, 'hB001));
      tbl.push_back(mkv(0, 'h0000, 1, 0, 0, 0, 1, 0, 3, 'h0099, 0, 0, 'hB001));
      tbl.push_back(mkv(0, 'h0000, 0, 1, 'hC000, 1, 0, 0, 3, 'h0099, 0, 0, 'hB002));
      tbl.push_back(mkv(0, 'h0000, 0, 0, 0, 1, 0, 0, 2, 'h0099, 0, 0, 'hB003));
      tbl.push_back(mkv(0, 'h0000, 0, 0, 0, 1, 0, 0, 1, 'h0099, 0, 0, 'hC000));
      tbl.push_back(mkv(0, 'h0000, 0, 0, 0, 1, 0, 0, 0, 'h0099, 0, 0, 'h0000));

      // Reset, then idle.
      #12;
      rst = 1'b1;
      model_reset();
      step(0, 0, 0, 0, 0, 0, 0);
      check("reset_idle", dut_bundle(), pack(1, 0, 0, 0, 16'h0, 16'h0, 0, 0));

      foreach (tbl[i]) begin
         vec_t v = tbl[i];
         step(v.iv, v.id, v.rd, v.wr, v.wd, v.ordy, v.clr);
         check($sformatf("table[%0d]", i), dut_bundle(),
               pack(v.e_inc != 3'(D), v.e_outc != 0, v.e_inc, v.e_outc, v.e_rd, v.e_od,
                    v.e_uf, v.e_of));
      end

      // Asynchronous reset in the middle of a cycle with three words queued.
      step(1, 'h0101, 0, 0, 0, 0, 0);
      step(1, 'h0202, 0, 0, 0, 0, 0);
      step(1, 'h0303, 0, 0, 0, 0, 0);
      check("pre_reset_inc", dut_bundle(), model_bundle());
      @(negedge clk);
      ext_in_valid = 1'b0;
      #2 rst = 1'b0;
      #1;
      check("async_reset", dut_bundle(), pack(1, 0, 0, 0, 16'h0, 16'h0, 0, 0));
      @(negedge clk);
      rst = 1'b1;
      model_reset();
      step(0, 0, 1, 0, 0, 0, 0);
      check("read_after_reset", dut_bundle(), pack(1, 0, 0, 0, 16'h0, 16'h0, 1, 0));

      // Randomized traffic against the model.
      for (int n = 0; n < 3000; n++) begin
         step($urandom_range(0, 1) == 1, 16'($urandom), $urandom_range(0, 9) < 4,
              $urandom_range(0, 9) < 4, 16'($urandom), $urandom_range(0, 1) == 1,
              $urandom_range(0, 9) == 0);
         check($sformatf("random[%0d]", n), dut_bundle(), model_bundle());
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
